// File: rtl/note_voice_alloc.sv
// Polyphonic voice allocator: assigns note-on/off/all-off commands to voice slots
// with age-ranked stealing of the least-recently-allocated voice.
module note_voice_alloc #(
  parameter int unsigned N_VOICES = 4,
  parameter int unsigned FCW_W    = 24
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_kind,
  input  logic [FCW_W-1:0]            cmd_fcw,
  output logic [N_VOICES*FCW_W-1:0]   carrier_fcws,
  output logic [N_VOICES-1:0]         note_en,
  output logic                        voices_full,
  output logic                        steal
);

  localparam int unsigned IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam logic [1:0] KIND_ON  = 2'b00;
  localparam logic [1:0] KIND_OFF = 2'b01;
  localparam logic [1:0] KIND_ALL = 2'b10;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_e;

  state_e                 state_q;
  logic                   ready_q;
  logic                   steal_q;
  logic [1:0]             kind_q;
  logic [FCW_W-1:0]       lfcw_q;
  logic [IDX_W-1:0]       idx_q;
  logic [N_VOICES-1:0]    match_q;
  logic                   free_found_q;
  logic [IDX_W-1:0]       free_idx_q;
  logic [IDX_W-1:0]       oldest_q;
  logic [N_VOICES-1:0]    en_q;
  logic [FCW_W-1:0]       fcw_q  [N_VOICES];
  logic [IDX_W-1:0]       rank_q [N_VOICES];

  logic [IDX_W-1:0]       match_lo;
  logic [IDX_W-1:0]       alloc_idx;
  logic                   evict;
  logic [IDX_W-1:0]       rank_d [N_VOICES];

  // Target voice for a note-on and the age ranks after allocating it
  always_comb begin
    match_lo  = '0;
    alloc_idx = '0;
    evict     = 1'b0;
    for (int v = int'(N_VOICES) - 1; v >= 0; v--) begin
      if (match_q[v]) match_lo = IDX_W'(v);
    end
    if (|match_q) begin
      alloc_idx = match_lo;
    end else if (free_found_q) begin
      alloc_idx = free_idx_q;
    end else begin
      alloc_idx = oldest_q;
      evict     = 1'b1;
    end
    for (int v = 0; v < int'(N_VOICES); v++) begin
      rank_d[v] = rank_q[v];
      if (rank_q[v] < rank_q[alloc_idx]) rank_d[v] = rank_q[v] + IDX_W'(1);
      if (IDX_W'(v) == alloc_idx) rank_d[v] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      steal_q      <= 1'b0;
      kind_q       <= 2'b00;
      lfcw_q       <= '0;
      idx_q        <= '0;
      match_q      <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      oldest_q     <= '0;
      en_q         <= '0;
      for (int v = 0; v < int'(N_VOICES); v++) begin
        fcw_q[v]  <= '0;
        rank_q[v] <= IDX_W'(int'(N_VOICES) - 1 - v);
      end
    end else begin
      steal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            kind_q       <= cmd_kind;
            lfcw_q       <= cmd_fcw;
            ready_q      <= 1'b0;
            idx_q        <= '0;
            match_q      <= '0;
            free_found_q <= 1'b0;
            free_idx_q   <= '0;
            oldest_q     <= '0;
            state_q      <= (cmd_kind == KIND_ALL) ? COMMIT : SCAN;
          end
        end
        SCAN: begin
          match_q[idx_q] <= en_q[idx_q] && (fcw_q[idx_q] == lfcw_q);
          if (!free_found_q && !en_q[idx_q]) begin
            free_found_q <= 1'b1;
            free_idx_q   <= idx_q;
          end
          if (rank_q[idx_q] == IDX_W'(N_VOICES - 1)) oldest_q <= idx_q;
          if (idx_q == IDX_W'(N_VOICES - 1)) state_q <= COMMIT;
          else idx_q <= idx_q + IDX_W'(1);
        end
        COMMIT: begin
          case (kind_q)
            KIND_ON: begin
              for (int v = 0; v < int'(N_VOICES); v++) rank_q[v] <= rank_d[v];
              if (!(|match_q)) begin
                fcw_q[alloc_idx] <= lfcw_q;
                en_q[alloc_idx]  <= 1'b1;
                steal_q          <= evict;
              end
            end
            KIND_OFF: en_q <= en_q & ~match_q;
            KIND_ALL: en_q <= '0;
            default:  ;
          endcase
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < int'(N_VOICES); g++) begin : g_out
    assign carrier_fcws[g*FCW_W +: FCW_W] = fcw_q[g];
  end

  assign cmd_ready   = ready_q;
  assign note_en     = en_q;
  assign steal       = steal_q;
  assign voices_full = &en_q;

endmodule

// File: tb/tb_note_voice_alloc.sv
// Directed table-driven bench for note_voice_alloc (N_VOICES=4, FCW_W=24).
module tb_note_voice_alloc;

  localparam int unsigned NV = 4;
  localparam int unsigned FW = 24;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_kind;
  logic [FW-1:0]     cmd_fcw;
  logic [NV*FW-1:0]  carrier_fcws;
  logic [NV-1:0]     note_en;
  logic              voices_full;
  logic              steal;

  note_voice_alloc #(.N_VOICES(NV), .FCW_W(FW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_kind     (cmd_kind),
    .cmd_fcw      (cmd_fcw),
    .carrier_fcws (carrier_fcws),
    .note_en      (note_en),
    .voices_full  (voices_full),
    .steal        (steal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       kind;
    logic [FW-1:0]    fcw;
    logic [NV-1:0]    exp_en;
    logic [NV*FW-1:0] exp_fcws;
    int               exp_steals;
    int               exp_busy;
  } vec_t;

  vec_t vecs [24];
  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(input logic [1:0] k, input int f, input logic [3:0] en,
                              input int f0, input int f1, input int f2, input int f3,
                              input int st);
    vec_t r;
    r.kind       = k;
    r.fcw        = FW'(f);
    r.exp_en     = en;
    r.exp_fcws   = {FW'(f3), FW'(f2), FW'(f1), FW'(f0)};
    r.exp_steals = st;
    r.exp_busy   = (k == 2'b10) ? 1 : 5;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Issue one command, keep cmd_valid toggling while busy, return observations
  task automatic run_cmd(input logic [1:0] k, input logic [FW-1:0] f,
                         output int busy, output int steals, output logic [NV-1:0] en_pre);
    int guard;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_kind  = k;
    cmd_fcw   = f;
    @(negedge clk);
    busy = 0; steals = 0; en_pre = note_en; guard = 0;
    while (cmd_ready == 1'b0 && guard < 20) begin
      busy++;
      en_pre = note_en;
      if (steal) steals++;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_kind  = 2'b00;
      cmd_fcw   = FW'($urandom);
      guard++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (steal) steals++;
    @(negedge clk);
    if (steal) steals++;
  endtask

  task automatic run_range(input int lo, input int hi, input logic [NV-1:0] en_start);
    int busy, steals;
    logic [NV-1:0] en_pre;
    logic [NV-1:0] prev_en;
    prev_en = en_start;
    for (int i = lo; i <= hi; i++) begin
      run_cmd(vecs[i].kind, vecs[i].fcw, busy, steals, en_pre);
      chk($sformatf("vec%0d_busy", i), 128'(busy), 128'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_en_before_commit", i), 128'(en_pre), 128'(prev_en));
      chk($sformatf("vec%0d_note_en", i), 128'(note_en), 128'(vecs[i].exp_en));
      chk($sformatf("vec%0d_fcws", i), 128'(carrier_fcws), 128'(vecs[i].exp_fcws));
      chk($sformatf("vec%0d_full", i), 128'(voices_full), 128'(&vecs[i].exp_en));
      chk($sformatf("vec%0d_steals", i), 128'(steals), 128'(vecs[i].exp_steals));
      prev_en = vecs[i].exp_en;
    end
  endtask

  initial begin
    int st_cnt;
    // Segment A: basic allocation, refresh, note-off, all-off, stealing, FCW 0, reserved
    vecs[0]  = mk(2'b00, 2796202, 4'b0001, 2796202, 0, 0, 0, 0);
    vecs[1]  = mk(2'b00, 1006202, 4'b0011, 2796202, 1006202, 0, 0, 0);
    vecs[2]  = mk(2'b00, 2796202, 4'b0011, 2796202, 1006202, 0, 0, 0);
    vecs[3]  = mk(2'b01, 2796202, 4'b0010, 2796202, 1006202, 0, 0, 0);
    vecs[4]  = mk(2'b00, 1118481, 4'b0011, 1118481, 1006202, 0, 0, 0);
    vecs[5]  = mk(2'b01, 555,     4'b0011, 1118481, 1006202, 0, 0, 0);
    vecs[6]  = mk(2'b10, 0,       4'b0000, 1118481, 1006202, 0, 0, 0);
    vecs[7]  = mk(2'b00, 100,     4'b0001, 100, 1006202, 0, 0, 0);
    vecs[8]  = mk(2'b00, 200,     4'b0011, 100, 200, 0, 0, 0);
    vecs[9]  = mk(2'b00, 300,     4'b0111, 100, 200, 300, 0, 0);
    vecs[10] = mk(2'b00, 400,     4'b1111, 100, 200, 300, 400, 0);
    vecs[11] = mk(2'b00, 500,     4'b1111, 500, 200, 300, 400, 1);
    vecs[12] = mk(2'b00, 600,     4'b1111, 500, 600, 300, 400, 1);
    vecs[13] = mk(2'b00, 300,     4'b1111, 500, 600, 300, 400, 0);
    vecs[14] = mk(2'b00, 0,       4'b1111, 500, 600, 300, 0, 1);
    vecs[15] = mk(2'b01, 0,       4'b0111, 500, 600, 300, 0, 0);
    vecs[16] = mk(2'b11, 500,     4'b0111, 500, 600, 300, 0, 0);
    vecs[17] = mk(2'b01, 500,     4'b0110, 500, 600, 300, 0, 0);
    vecs[18] = mk(2'b00, 700,     4'b0111, 700, 600, 300, 0, 0);
    // Segment B: after a mid-SCAN reset, ranks restart so voice 0 is oldest again
    vecs[19] = mk(2'b00, 10, 4'b0001, 10, 0, 0, 0, 0);
    vecs[20] = mk(2'b00, 20, 4'b0011, 10, 20, 0, 0, 0);
    vecs[21] = mk(2'b00, 30, 4'b0111, 10, 20, 30, 0, 0);
    vecs[22] = mk(2'b00, 40, 4'b1111, 10, 20, 30, 40, 0);
    vecs[23] = mk(2'b00, 50, 4'b1111, 50, 20, 30, 40, 1);

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_kind = 2'b00; cmd_fcw = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 128'(cmd_ready), 128'(1));
    chk("reset_note_en", 128'(note_en), 128'(0));
    chk("reset_fcws", 128'(carrier_fcws), 128'(0));
    chk("reset_steal", 128'(steal), 128'(0));
    chk("reset_full", 128'(voices_full), 128'(0));
    rst_n = 1'b1;

    run_range(0, 18, 4'b0000);

    // Reset asserted while a note-on is in SCAN
    @(negedge clk);
    cmd_valid = 1'b1; cmd_kind = 2'b00; cmd_fcw = FW'(900);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre_reset_busy", 128'(cmd_ready), 128'(0));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_note_en", 128'(note_en), 128'(0));
    chk("midreset_ready", 128'(cmd_ready), 128'(1));
    chk("midreset_fcws", 128'(carrier_fcws), 128'(0));
    chk("midreset_steal", 128'(steal), 128'(0));
    rst_n = 1'b1;
    st_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (steal || note_en != 4'b0000) st_cnt++;
    end
    chk("post_reset_quiet", 128'(st_cnt), 128'(0));

    run_range(19, 23, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
